// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq -- iterative RV32M multiply/divide unit for the Execute stage.
//
// Handles one M-extension op at a time on a shared 64-bit accumulator. There
// is one shift/add (multiply) or shift/subtract (divide) step per cycle, 32
// steps per op. Divide-by-zero and signed overflow skip the iteration and
// finish in one cycle with a fixed result.
//
// Ports
//   clk      in   clock, all state changes on posedge
//   clr      in   synchronous active-high reset
//   startE   in   M-extension instruction valid in Execute
//   funct3E  in   [2:0] op: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   SrcAE    in   [31:0] rs1 operand (forwarded)
//   SrcBE    in   [31:0] rs2 operand (forwarded)
//   flushE   in   Execute flush, aborts any op in flight
//   busyE    out  stall request to the hazard unit (combinational)
//   doneE    out  one-cycle pulse, ResultE valid
//   ResultE  out  [31:0] registered result
// ---------------------------------------------------------------------------
module muldiv_seq (
   input  logic        clk,
   input  logic        clr,
   input  logic        startE,
   input  logic [2:0]  funct3E,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic        flushE,
   output logic        busyE,
   output logic        doneE,
   output logic [31:0] ResultE
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  f3;       // latched op
   logic [4:0]  cnt;      // iterations remaining minus one
   logic [63:0] acc;      // product, or {remainder, dividend/quotient}
   logic [31:0] opb;      // multiplicand or divisor magnitude
   logic        negq;     // product / quotient sign
   logic        negr;     // remainder sign

   // ---------------- start-cycle operand decode ----------------
   logic        a_sgn, b_sgn, sA, sB;
   logic [31:0] magA, magB;
   logic        div_zero, div_ovf, special;
   logic [31:0] spec_res;

   // Signed-A ops: MULH, MULHSU, DIV, REM. Signed-B ops: MULH, DIV, REM.
   assign a_sgn = (funct3E == 3'b001) | (funct3E == 3'b010) |
                  (funct3E == 3'b100) | (funct3E == 3'b110);
   assign b_sgn = (funct3E == 3'b001) | (funct3E == 3'b100) |
                  (funct3E == 3'b110);
   assign sA    = a_sgn & SrcAE[31];
   assign sB    = b_sgn & SrcBE[31];
   // abs(0x80000000) stays 0x80000000, which is correct as an unsigned magnitude
   assign magA  = sA ? (~SrcAE + 32'd1) : SrcAE;
   assign magB  = sB ? (~SrcBE + 32'd1) : SrcBE;

   assign div_zero = funct3E[2] & (SrcBE == 32'd0);
   // Only the signed forms (DIV=100, REM=110) can overflow
   assign div_ovf  = funct3E[2] & ~funct3E[0] &
                     (SrcAE == 32'h8000_0000) & (SrcBE == 32'hFFFF_FFFF);
   assign special  = div_zero | div_ovf;

   always_comb begin
      spec_res = 32'd0;
      if (div_zero) spec_res = funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
      else          spec_res = funct3E[1] ? 32'd0 : 32'h8000_0000;
   end

   // ---------------- one iteration of the datapath ----------------
   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;
   logic [32:0] rem_sh, div_diff;
   logic        div_ge;
   logic [63:0] div_nxt;
   logic [63:0] acc_nxt;

   // Multiply: multiplier sits in acc[31:0] and shifts out LSB-first while
   // the partial product grows down from the top; carry goes into bit 63.
   assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
   assign mul_nxt = {mul_sum, acc[31:1]};

   // Restoring divide: shift {rem, dividend} left, try to subtract the divisor
   // from the 33-bit partial remainder, shift the quotient bit in at the bottom.
   assign rem_sh   = acc[63:31];
   assign div_ge   = rem_sh >= {1'b0, opb};
   assign div_diff = rem_sh - {1'b0, opb};
   assign div_nxt  = div_ge ? {div_diff[31:0], acc[30:0], 1'b1}
                            : {acc[62:0], 1'b0};

   assign acc_nxt = f3[2] ? div_nxt : mul_nxt;

   // ---------------- sign fix-up and result select ----------------
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;
   logic [31:0] final_res;

   assign prod_fix = negq ? (~acc_nxt + 64'd1) : acc_nxt;
   assign quot_fix = negq ? (~acc_nxt[31:0] + 32'd1) : acc_nxt[31:0];
   assign rem_fix  = negr ? (~acc_nxt[63:32] + 32'd1) : acc_nxt[63:32];

   always_comb begin
      final_res = 32'd0;
      case (f3)
         3'b000:                 final_res = prod_fix[31:0];
         3'b001, 3'b010, 3'b011: final_res = prod_fix[63:32];
         3'b100, 3'b101:         final_res = quot_fix;
         default:                final_res = rem_fix;
      endcase
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      if (flushE) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (startE) state_nxt = special ? DONE : CALC;
            CALC:    if (cnt == 5'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // busyE is combinational so the stall already applies in the start cycle.
   always_comb begin
      busyE = ((state == IDLE) & startE & ~flushE) | (state == CALC);
      doneE = (state == DONE) & ~flushE;
   end

   // ---------------- datapath registers ----------------
   // A flush blocks every update, so an aborted op never touches ResultE.
   always_ff @(posedge clk) begin
      if (clr) begin
         f3      <= 3'd0;
         cnt     <= 5'd0;
         acc     <= 64'd0;
         opb     <= 32'd0;
         negq    <= 1'b0;
         negr    <= 1'b0;
         ResultE <= 32'd0;
      end else if (!flushE) begin
         case (state)
            IDLE: begin
               if (startE) begin
                  f3   <= funct3E;
                  cnt  <= 5'd31;
                  acc  <= {32'd0, magA};
                  opb  <= magB;
                  negq <= sA ^ sB;
                  negr <= sA;
                  if (special) ResultE <= spec_res;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               if (cnt == 5'd0) ResultE <= final_res;
               else             cnt     <= cnt - 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq -- directed scoreboard bench for muldiv_seq.
// Stimulus pushes {expected result, expected done cycle} onto queues. A
// monitor pops and compares whenever doneE is seen.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        clr;
   logic        startE;
   logic [2:0]  funct3E;
   logic [31:0] SrcAE, SrcBE;
   logic        flushE;
   logic        busyE, doneE;
   logic [31:0] ResultE;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [31:0] exp_q[$];
   int          cyc_q[$];
   logic [31:0] last_res;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010,
      MULHU = 3'b011, DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   muldiv_seq dut (
      .clk(clk), .clr(clr), .startE(startE), .funct3E(funct3E),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .flushE(flushE),
      .busyE(busyE), .doneE(doneE), .ResultE(ResultE)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (doneE === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got result %h want no doneE (cycle %0d)", ResultE, cyc);
         end else begin
            logic [31:0] e;
            int          c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk("result", ResultE, e);
            chk("done_cycle", cyc, c);
         end
      end
   end

   // Called at #1 after a posedge; start cycle is the current one.
   // lat is the done cycle offset (33 normal, 1 special).
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int lat);
      startE = 1'b1; funct3E = f; SrcAE = a; SrcBE = b;
      exp_q.push_back(expv);
      cyc_q.push_back(cyc + lat);
      last_res = expv;
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         chk("busy", {31'd0, busyE}, {31'd0, (k < lat)});
         @(posedge clk); #1;
         startE = 1'b0;
         SrcAE  = $urandom;   // operands must not matter after the start cycle
         SrcBE  = $urandom;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      clr = 1'b1; startE = 1'b0; funct3E = 3'd0; SrcAE = 0; SrcBE = 0; flushE = 1'b0;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      chk("rst_result", ResultE, 32'd0);
      chk("rst_done", {31'd0, doneE}, 32'd0);
      chk("rst_busy", {31'd0, busyE}, 32'd0);
      @(posedge clk); #1;

      // multiplies
      run_op(MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      // divides
      run_op(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_op(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op(DIVU, 32'd100, 32'd7, 32'd14, 33);
      run_op(REMU, 32'd100, 32'd7, 32'd2, 33);
      run_op(DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      run_op(REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
      // special cases
      run_op(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op(REMU, 32'd5, 32'd0, 32'd5, 1);
      run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      run_op(REM,  32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFD, 1);

      // flush in cycle 10 of a DIV (not pushed: no doneE may appear)
      startE = 1'b1; funct3E = DIV; SrcAE = 32'd1000; SrcBE = 32'd3;
      @(posedge clk); #1 startE = 1'b0;
      repeat (9) @(posedge clk);
      #1 flushE = 1'b1;
      @(negedge clk);
      chk("flush_nodone", {31'd0, doneE}, 32'd0);
      @(posedge clk); #1 flushE = 1'b0;
      #1;
      chk("flush_idle_busy", {31'd0, busyE}, 32'd0);
      chk("flush_result_hold", ResultE, last_res);
      run_op(MUL, 32'h0001_0000, 32'h0000_0300, 32'h0300_0000, 33);

      // clr in cycle 20 of a MUL, together with startE
      startE = 1'b1; funct3E = MUL; SrcAE = 32'd3; SrcBE = 32'd3;
      @(posedge clk); #1 startE = 1'b0;
      repeat (19) @(posedge clk);
      #1 clr = 1'b1; startE = 1'b1;
      @(posedge clk); #1 clr = 1'b0; startE = 1'b0;
      @(negedge clk);
      chk("clr_result", ResultE, 32'd0);
      chk("clr_done", {31'd0, doneE}, 32'd0);
      chk("clr_busy", {31'd0, busyE}, 32'd0);
      @(posedge clk); #1;
      // back-to-back: done cycles 33 and 67 relative to the first start
      run_op(MUL, 32'd12345, 32'd1000, 32'd12345000, 33);
      run_op(MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);

      repeat (3) @(posedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
